ddr3_cmd_sequencer: RTL

Upstream command sequencer that drives the DDR3 command state machine's one-cycle command-pulse inputs (ZQCL, MRS, REF, ACT, WRITE, READ, WRITE_AP, READ_AP, PRE) together with its address, bank and write-data inputs.
- After reset, runs a fixed init sequence: wait, ZQCL, MRS.
- Then accepts host read/write requests over a valid/ready handshake and expands each into a timed close-page command sequence.
- Issues periodic refresh, with refresh taking priority over new requests.

---
 rtl/ddr3_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_cmd_sequencer.sv
// ddr3_cmd_sequencer: power-up init (wait, ZQCL, MRS), host request
// expansion into close-page ACT/RW/PRE sequences, periodic refresh.
// Ports:
//   CLK, RESET (async active-low)
//   req_valid/req_ready + req_write/ap/bank/row/col/wdata : host request
//   ZQCL MRS REF ACT WRITE READ WRITE_AP READ_AP PRE : 1-cycle pulses
//   BA_in Addr_Row Addr_Column A_10 DQ_in : latched request fields
//   init_done (level), req_done (pulse)
module ddr3_cmd_sequencer #(
  parameter int T_INIT = 16,
  parameter int T_ZQ   = 8,
  parameter int T_MRD  = 4,
  parameter int T_RCD  = 3,
  parameter int T_WR   = 6,
  parameter int T_RTP  = 4,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 8,
  parameter int T_REFI = 200,
  parameter int CW     = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_ap,
  input  logic [2:0]  req_bank,
  input  logic [14:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [15:0] req_wdata,
  output logic        ZQCL,
  output logic        MRS,
  output logic        REF,
  output logic        ACT,
  output logic        WRITE,
  output logic        READ,
  output logic        WRITE_AP,
  output logic        READ_AP,
  output logic        PRE,
  output logic [2:0]  BA_in,
  output logic [14:0] Addr_Row,
  output logic [9:0]  Addr_Column,
  output logic        A_10,
  output logic [15:0] DQ_in,
  output logic        init_done,
  output logic        req_done
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ZQ,
    S_MRD,
    S_IDLE,
    S_RCD,
    S_RW,
    S_RP,
    S_RFC
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_refcnt;
  logic          r_ref_pend;
  logic          r_init_done;
  logic          r_req_ready;
  logic          r_req_done;
  logic          r_wr;
  logic          r_ap;
  logic [2:0]    r_ba;
  logic [14:0]   r_row;
  logic [9:0]    r_col;
  logic [15:0]   r_wd;
  logic          r_zqcl;
  logic          r_mrs;
  logic          r_ref;
  logic          r_act;
  logic          r_write;
  logic          r_read;
  logic          r_write_ap;
  logic          r_read_ap;
  logic          r_pre;

  logic          w_wrap;
  logic          w_pend_nxt;
  logic          w_hs;
  logic [CW-1:0] w_rw_wait;
  logic [CW-1:0] w_cnt_inc;

  assign w_wrap     = r_init_done &&
                      (r_refcnt == CW'(T_REFI - 1));
  // Readiness must see a wrap landing on the same edge,
  // otherwise a handshake could slip past a fresh refresh.
  assign w_pend_nxt = r_ref_pend | w_wrap;
  assign w_hs       = req_valid & r_req_ready;
  assign w_rw_wait  = r_wr ? CW'(T_WR) : CW'(T_RTP);
  assign w_cnt_inc  = r_cnt + CW'(1);

  assign req_ready   = r_req_ready;
  assign init_done   = r_init_done;
  assign req_done    = r_req_done;
  assign ZQCL        = r_zqcl;
  assign MRS         = r_mrs;
  assign REF         = r_ref;
  assign ACT         = r_act;
  assign WRITE       = r_write;
  assign READ        = r_read;
  assign WRITE_AP    = r_write_ap;
  assign READ_AP     = r_read_ap;
  assign PRE         = r_pre;
  assign BA_in       = r_ba;
  assign Addr_Row    = r_row;
  assign Addr_Column = r_col;
  assign A_10        = r_ap;
  assign DQ_in       = r_wd;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_refcnt <= '0;
    end else if (r_init_done) begin
      r_refcnt <= w_wrap ? '0 : r_refcnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_ref_pend  <= 1'b0;
      r_init_done <= 1'b0;
      r_req_ready <= 1'b0;
      r_req_done  <= 1'b0;
      r_wr        <= 1'b0;
      r_ap        <= 1'b0;
      r_ba        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_wd        <= '0;
      r_zqcl      <= 1'b0;
      r_mrs       <= 1'b0;
      r_ref       <= 1'b0;
      r_act       <= 1'b0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_write_ap  <= 1'b0;
      r_read_ap   <= 1'b0;
      r_pre       <= 1'b0;
    end else begin
      r_zqcl     <= 1'b0;
      r_mrs      <= 1'b0;
      r_ref      <= 1'b0;
      r_act      <= 1'b0;
      r_write    <= 1'b0;
      r_read     <= 1'b0;
      r_write_ap <= 1'b0;
      r_read_ap  <= 1'b0;
      r_pre      <= 1'b0;
      r_req_done <= 1'b0;
      r_ref_pend <= w_pend_nxt;
      // r_cnt holds cycles elapsed since the last pulse
      unique case (r_state)
        S_INIT: begin
          if (r_cnt == CW'(T_INIT)) begin
            r_zqcl  <= 1'b1;
            r_cnt   <= CW'(1);
            r_state <= S_ZQ;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_ZQ: begin
          if (r_cnt == CW'(T_ZQ)) begin
            r_mrs   <= 1'b1;
            r_cnt   <= CW'(1);
            r_state <= S_MRD;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_MRD: begin
          if (r_cnt == CW'(T_MRD)) begin
            r_init_done <= 1'b1;
            r_req_ready <= !w_pend_nxt;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_IDLE: begin
          if (r_ref_pend) begin
            r_ref       <= 1'b1;
            r_ref_pend  <= w_wrap;
            r_req_ready <= 1'b0;
            r_cnt       <= CW'(1);
            r_state     <= S_RFC;
          end else if (w_hs) begin
            r_wr        <= req_write;
            r_ap        <= req_ap;
            r_ba        <= req_bank;
            r_row       <= req_row;
            r_col       <= req_col;
            r_wd        <= req_wdata;
            r_act       <= 1'b1;
            r_req_ready <= 1'b0;
            r_cnt       <= CW'(1);
            r_state     <= S_RCD;
          end else begin
            r_req_ready <= !w_pend_nxt;
          end
        end
        S_RCD: begin
          if (r_cnt == CW'(T_RCD)) begin
            unique case (1'b1)
              r_wr && !r_ap:  r_write    <= 1'b1;
              r_wr && r_ap:   r_write_ap <= 1'b1;
              !r_wr && !r_ap: r_read     <= 1'b1;
              !r_wr && r_ap:  r_read_ap  <= 1'b1;
            endcase
            r_cnt   <= CW'(1);
            r_state <= S_RW;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RW: begin
          // with auto-precharge the PRE slot stays silent
          // but the T_RP wait still follows it
          if (r_cnt == w_rw_wait) begin
            r_pre   <= !r_ap;
            r_cnt   <= CW'(1);
            r_state <= S_RP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RP: begin
          if (r_cnt == CW'(T_RP)) begin
            r_req_done  <= 1'b1;
            r_req_ready <= !w_pend_nxt;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RFC: begin
          if (r_cnt == CW'(T_RFC)) begin
            r_req_ready <= !w_pend_nxt;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

endmodule
